// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port byte-serial memory controller in front of a single
// 8-bit RAM port. Arbitrates one transaction at a time, serialises byte/half/
// word loads and stores, and sign/zero-extends load data.
//
// Optional feature macro: MEMARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration starting after the last granted port
//   undefined -> fixed priority, lowest port index wins
//
// Ports:
//   clockIn    clock, posedge
//   resetIn    synchronous active-high reset
//   readyIn    global enable; low freezes all state
//   clearIn    flush (ignored while a store is in flight)
//   reqFlag    per-port request, held until the matching okOut bit
//   reqOp      per port [3]=unsigned load, [2]=store, [1:0]=size
//   reqAddr    per-port byte address
//   reqData    per-port store data, little-endian
//   okOut      one-hot completion pulse
//   grantOut   one-hot owner of the current transaction (0 when idle)
//   dataOut    last completed load result
//   busyOut    high while a transaction is in progress
//   ramSelect  1 = read, 0 = write
//   ramAddr    RAM byte address
//   ramOut     RAM write byte
//   ramIn      RAM read byte, valid the cycle after its address
module mem_arbiter_rr #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned NUM_PORTS  = 3
) (
  input  logic                      clockIn,
  input  logic                      resetIn,
  input  logic                      readyIn,
  input  logic                      clearIn,
  input  logic [NUM_PORTS-1:0]      reqFlag,
  input  logic [4*NUM_PORTS-1:0]    reqOp,
  input  logic [32*NUM_PORTS-1:0]   reqAddr,
  input  logic [32*NUM_PORTS-1:0]   reqData,
  output logic [NUM_PORTS-1:0]      okOut,
  output logic [NUM_PORTS-1:0]      grantOut,
  output logic [31:0]               dataOut,
  output logic                      busyOut,
  output logic                      ramSelect,
  output logic [ADDR_WIDTH-1:0]     ramAddr,
  output logic [7:0]                ramOut,
  input  logic [7:0]                ramIn
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [23:0]             buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [NUM_PORTS-1:0]    ok_q, ok_d;
  logic [31:0]             data_q, data_d;
`ifdef MEMARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [PTR_W-1:0]        probe_c;
`endif

  logic [NUM_PORTS-1:0]    cand_c;
  logic                    win_vld_c;
  logic [PTR_W-1:0]        win_c;
  logic [3:0]              win_op_c;
  logic [ADDR_WIDTH-1:0]   win_addr_c;
  logic [31:0]             win_data_c;
  logic [2:0]              len_c;
  logic                    unused_addr_c;

  // Address bits above ADDR_WIDTH are deliberately ignored (RAM wraps).
  assign unused_addr_c = ^reqAddr;

  // Transfer length in bytes; size 2'b10 behaves as a word.
  assign len_c = (size_q == 2'b00) ? 3'd1 :
                 (size_q == 2'b01) ? 3'd2 : 3'd4;

  // Arbitration; the port currently receiving ok is not a candidate.
  always_comb begin
    cand_c    = reqFlag & ~ok_q;
    win_vld_c = 1'b0;
    win_c     = '0;
`ifdef MEMARB_ROUND_ROBIN_EN
    probe_c   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      probe_c = PTR_W'((32'(rr_q) + 32'd1 + k) % NUM_PORTS);
      if (!win_vld_c && cand_c[probe_c]) begin
        win_vld_c = 1'b1;
        win_c     = probe_c;
      end
    end
`else
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!win_vld_c && cand_c[PTR_W'(k)]) begin
        win_vld_c = 1'b1;
        win_c     = PTR_W'(k);
      end
    end
`endif
  end

  // Winner's request fields.
  always_comb begin
    win_op_c   = '0;
    win_addr_c = '0;
    win_data_c = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (win_c == PTR_W'(k)) begin
        win_op_c   = reqOp[k*4 +: 4];
        win_addr_c = reqAddr[k*32 +: ADDR_WIDTH];
        win_data_c = reqData[k*32 +: 32];
      end
    end
  end

  // Next-state and RAM-side outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    base_d    = base_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    grant_d   = grant_q;
    ok_d      = ok_q;
    data_d    = data_q;
`ifdef MEMARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    ramSelect = 1'b1;
    ramAddr   = '0;
    ramOut    = '0;

    case (state_q)
      S_IDLE: begin
        if (readyIn) begin
          ok_d = '0;
          if (clearIn) begin
            idx_d = '0;
          end else if (win_vld_c) begin
            ramAddr        = win_addr_c;
            base_d         = win_addr_c;
            size_d         = win_op_c[1:0];
            uns_d          = win_op_c[3];
            wdata_d        = win_data_c;
            grant_d        = '0;
            grant_d[win_c] = 1'b1;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_d           = win_c;
`endif
            if (win_op_c[2]) begin
              state_d = S_STORE;
              idx_d   = 3'd0;
            end else begin
              // Byte 0 address goes out now, so the load starts at index 1.
              state_d = S_LOAD;
              idx_d   = 3'd1;
            end
          end
        end
      end

      S_LOAD: begin
        if (idx_q < len_c) begin
          ramAddr = base_q + ADDR_WIDTH'(idx_q);
        end
        if (readyIn) begin
          if (clearIn) begin
            state_d = S_IDLE;
            idx_d   = '0;
            ok_d    = '0;
            grant_d = '0;
          end else begin
            case (idx_q)
              3'd1:    buf_d[7:0]   = ramIn;
              3'd2:    buf_d[15:8]  = ramIn;
              3'd3:    buf_d[23:16] = ramIn;
              default: ;
            endcase
            if (idx_q == len_c) begin
              // ramIn is the final byte; extend from it directly.
              state_d = S_IDLE;
              idx_d   = '0;
              ok_d    = grant_q;
              grant_d = '0;
              case (size_q)
                2'b00:   data_d = {{24{~uns_q & ramIn[7]}}, ramIn};
                2'b01:   data_d = {{16{~uns_q & ramIn[7]}}, ramIn, buf_q[7:0]};
                default: data_d = {ramIn, buf_q[23:0]};
              endcase
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end

      S_STORE: begin
        ramAddr = base_q + ADDR_WIDTH'(idx_q);
        // Flush does not abort a store once bytes have started going out.
        if (readyIn) begin
          ramSelect = 1'b0;
          ramOut    = 8'(wdata_q >> {idx_q[1:0], 3'b000});
          if (idx_q == len_c - 3'd1) begin
            state_d = S_IDLE;
            idx_d   = '0;
            ok_d    = grant_q;
            grant_d = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      base_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      grant_q <= '0;
      ok_q    <= '0;
      data_q  <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
      rr_q    <= PTR_W'(NUM_PORTS - 1);
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      base_q  <= base_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      ok_q    <= ok_d;
      data_q  <= data_d;
`ifdef MEMARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign okOut    = ok_q;
  assign grantOut = grant_q;
  assign dataOut  = data_q;
  assign busyOut  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed scoreboard bench for mem_arbiter_rr with a byte-wide RAM model.
module tb_mem_arbiter_rr;

  localparam int AW = 17;
  localparam int NP = 3;

  typedef struct {
    int          port;
    bit          is_load;
    logic [31:0] data;
  } exp_t;

  logic              clk;
  logic              resetIn;
  logic              readyIn;
  logic              clearIn;
  logic [NP-1:0]     reqFlag;
  logic [4*NP-1:0]   reqOp;
  logic [32*NP-1:0]  reqAddr;
  logic [32*NP-1:0]  reqData;
  logic [NP-1:0]     okOut;
  logic [NP-1:0]     grantOut;
  logic [31:0]       dataOut;
  logic              busyOut;
  logic              ramSelect;
  logic [AW-1:0]     ramAddr;
  logic [7:0]        ramOut;
  logic [7:0]        ramIn = 8'h00;

  logic [7:0]        mem     [0:(1<<AW)-1];
  bit                written [0:(1<<AW)-1];

  exp_t              sb[$];
  int                errors = 0;
  int                checks = 0;
  logic [31:0]       last_data;
  logic [NP-1:0]     exp_g [4];

  mem_arbiter_rr #(.ADDR_WIDTH(AW), .NUM_PORTS(NP)) dut (
    .clockIn   (clk),
    .resetIn   (resetIn),
    .readyIn   (readyIn),
    .clearIn   (clearIn),
    .reqFlag   (reqFlag),
    .reqOp     (reqOp),
    .reqAddr   (reqAddr),
    .reqData   (reqData),
    .okOut     (okOut),
    .grantOut  (grantOut),
    .dataOut   (dataOut),
    .busyOut   (busyOut),
    .ramSelect (ramSelect),
    .ramAddr   (ramAddr),
    .ramOut    (ramOut),
    .ramIn     (ramIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    case (a)
      17'h00010: return 8'h11;
      17'h00011: return 8'h22;
      17'h00012: return 8'h33;
      17'h00013: return 8'h44;
      17'h00020: return 8'h80;
      17'h00030: return 8'h01;
      17'h00031: return 8'h90;
      default:   return a[7:0] ^ {a[11:8], a[15:12]} ^ {7'b0, a[16]} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [AW-1:0] a);
    return written[a] ? mem[a] : init_byte(a);
  endfunction

  // RAM stalls together with the rest of the system when readyIn is low.
  always @(posedge clk) begin
    if (readyIn) begin
      ramIn <= rd(ramAddr);
      if (!ramSelect) begin
        mem[ramAddr]     <= ramOut;
        written[ramAddr] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = rd(AW'(addr + 32'(i)));
    case (op[1:0])
      2'b00:   return {{24{~op[3] & b[0][7]}}, b[0]};
      2'b01:   return {{16{~op[3] & b[1][7]}}, b[1], b[0]};
      default: return {b[3], b[2], b[1], b[0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input int p, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int clr_at,
                        input int stall_at, input int stall_len);
    exp_t          e;
    int            n;
    int            lat;
    int            eff;
    bit            got;
    bit            rdy;
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    n    = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    base = addr[AW-1:0];
    @(posedge clk); #1;
    reqFlag[p]          = 1'b1;
    reqOp[p*4 +: 4]     = op;
    reqAddr[p*32 +: 32] = addr;
    reqData[p*32 +: 32] = wdata;
    e.port    = p;
    e.is_load = !op[2];
    e.data    = op[2] ? wdata : model_load(op, addr);
    sb.push_back(e);
    #1;
    chk("accept_addr", 32'(ramAddr), 32'(base));
    chk("accept_grant", 32'(grantOut), 32'd0);
    lat = 0; eff = 0; got = 1'b0;
    while (!got && lat < 40) begin
      rdy = readyIn;
      @(posedge clk); #1;
      lat++;
      if (rdy) eff++;
      clearIn = (lat == clr_at);
      readyIn = !(lat >= stall_at && lat < stall_at + stall_len);
      #1;
      if (okOut != '0) begin
        got = 1'b1;
      end else begin
        chk("busy_grant", 32'(grantOut), 32'(1) << p);
        if (op[2]) begin
          if (readyIn) begin
            ea = base + AW'(eff - 1);
            chk("store_sel", 32'(ramSelect), 32'd0);
            chk("store_addr", 32'(ramAddr), 32'(ea));
            chk("store_byte", 32'(ramOut), 32'(8'(wdata >> (8 * (eff - 1)))));
          end else begin
            chk("stall_sel", 32'(ramSelect), 32'd1);
            chk("stall_out", 32'(ramOut), 32'd0);
          end
        end else begin
          chk("load_sel", 32'(ramSelect), 32'd1);
          if (eff < n) begin
            ea = base + AW'(eff);
            chk("load_addr", 32'(ramAddr), 32'(ea));
          end
        end
      end
    end
    clearIn = 1'b0;
    readyIn = 1'b1;
    chk("ok_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(n + 1 + stall_len));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ok_port", 32'(okOut), 32'(1) << e.port);
      if (e.is_load) begin
        chk("load_data", dataOut, e.data);
        last_data = e.data;
      end else begin
        chk("data_held", dataOut, last_data);
        for (int i = 0; i < n; i++) begin
          ea = base + AW'(i);
          chk("store_mem", 32'(rd(ea)), 32'(8'(e.data >> (8 * i))));
        end
      end
    end
    reqFlag[p] = 1'b0;
  endtask

  initial begin
    int            ng;
    logic [NP-1:0] prev;

`ifdef MEMARB_ROUND_ROBIN_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
    // Port 0 is excluded during its own ok cycle, so port 1 gets every other slot.
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001; exp_g[3] = 3'b010;
`endif
    last_data = 32'h0;
    resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0;
    reqFlag = '0; reqOp = '0; reqAddr = '0; reqData = '0;
    repeat (3) @(posedge clk);
    #1 resetIn = 1'b0;
    #1;
    chk("rst_ok", 32'(okOut), 32'd0);
    chk("rst_grant", 32'(grantOut), 32'd0);
    chk("rst_data", dataOut, 32'd0);
    chk("rst_busy", 32'(busyOut), 32'd0);
    chk("rst_sel", 32'(ramSelect), 32'd1);
    chk("rst_addr", 32'(ramAddr), 32'd0);
    chk("rst_out", 32'(ramOut), 32'd0);

    // Word load on port 1.
    do_txn(1, 4'b0011, 32'h0000_0010, 32'h0, 0, 0, 0);
    chk("word_const", dataOut, 32'h4433_2211);

    // Half store wrapping the top of RAM.
    do_txn(2, 4'b0101, 32'h0001_FFFF, 32'h0000_BEEF, 0, 0, 0);
    chk("wrap_hi", 32'(rd(17'h1FFFF)), 32'h0000_00EF);
    chk("wrap_lo", 32'(rd(17'h00000)), 32'h0000_00BE);

    // Sign / zero extension.
    do_txn(0, 4'b0000, 32'h0000_0020, 32'h0, 0, 0, 0);
    chk("sbyte_const", dataOut, 32'hFFFF_FF80);
    do_txn(0, 4'b1000, 32'h0000_0020, 32'h0, 0, 0, 0);
    chk("ubyte_const", dataOut, 32'h0000_0080);
    do_txn(1, 4'b0001, 32'h0000_0030, 32'h0, 0, 0, 0);
    chk("shalf_const", dataOut, 32'hFFFF_9001);

    // Misaligned word across the wrap point, then size 2'b10 with high address bits set.
    do_txn(2, 4'b0011, 32'h0001_FFFE, 32'h0, 0, 0, 0);
    do_txn(0, 4'b1010, 32'h8000_0010, 32'h0, 0, 0, 0);
    chk("size10_const", dataOut, 32'h4433_2211);

    // Flush in the middle of a word load (index 2).
    @(posedge clk); #1;
    reqFlag[0] = 1'b1; reqOp[3:0] = 4'b0011; reqAddr[31:0] = 32'h0000_0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clearIn = 1'b1; reqFlag[0] = 1'b0;
    #1 chk("clr_pre_grant", 32'(grantOut), 32'd1);
    @(posedge clk); #1;
    clearIn = 1'b0;
    #1;
    chk("clr_busy", 32'(busyOut), 32'd0);
    chk("clr_grant", 32'(grantOut), 32'd0);
    chk("clr_ok", 32'(okOut), 32'd0);
    chk("clr_data", dataOut, last_data);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("clr_no_ok", 32'(okOut), 32'd0);
    end

    // Flush during a store is ignored.
    do_txn(1, 4'b0111, 32'h0000_0050, 32'hCAFE_F00D, 2, 0, 0);
    do_txn(0, 4'b0011, 32'h0000_0050, 32'h0, 0, 0, 0);
    chk("store_rb_const", dataOut, 32'hCAFE_F00D);

    // readyIn low for 3 cycles mid-load.
    do_txn(2, 4'b0011, 32'h0000_0010, 32'h0, 0, 2, 3);
    chk("stall_const", dataOut, 32'h4433_2211);

    // Reset in the middle of a load.
    @(posedge clk); #1;
    reqFlag[2] = 1'b1; reqOp[11:8] = 4'b0011; reqAddr[95:64] = 32'h0000_0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetIn = 1'b1; reqFlag = '0;
    @(posedge clk); #1;
    resetIn = 1'b0;
    #1;
    chk("mrst_busy", 32'(busyOut), 32'd0);
    chk("mrst_grant", 32'(grantOut), 32'd0);
    chk("mrst_ok", 32'(okOut), 32'd0);
    chk("mrst_data", dataOut, 32'd0);

    // All ports requesting byte loads continuously.
    @(posedge clk); #1;
    reqOp   = '0;
    reqAddr = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    reqFlag = '1;
    prev = '0; ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(posedge clk); #2;
      if (grantOut != '0 && prev == '0) begin
        chk("grant_order", 32'(grantOut), 32'(exp_g[ng]));
        ng++;
      end
      prev = grantOut;
    end
    chk("grant_count", 32'(ng), 32'd4);
    reqFlag = '0;
    repeat (5) @(posedge clk);
    #1 chk("final_idle", 32'(busyOut), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
